reg_dump_ctrl: RTL

//  Debug read-out engine on the read side of the CPU register file.
//  - On a start request, drives reg_src1/reg_src2 to sweep R0..R(NUM_REGS-1), two registers per fetch.
//  - Streams each 16-bit value out on a valid/ready port, tagged with its register index.
//  - Holds off CPU register writes for the whole dump, so the snapshot is coherent.

---
 rtl/reg_dump_ctrl_pkg.sv | 15 +
 rtl/reg_dump_ctrl_if.sv | 10 +
 rtl/reg_dump_ctrl.sv | 71 +++++++
 3 files changed

// File: rtl/reg_dump_ctrl_pkg.sv
// reg_dump_ctrl_pkg: widths, register count and dump FSM state encoding
package reg_dump_ctrl_pkg;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 8;
   localparam int PAIR_W   = $clog2(NUM_REGS / 2);
   localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_REGS / 2 - 1);
   typedef enum logic [2:0] {
      DUMP_IDLE   = 3'd0,
      DUMP_FETCH  = 3'd1,
      DUMP_SEND_A = 3'd2,
      DUMP_SEND_B = 3'd3,
      DUMP_DONE   = 3'd4
   } dump_state_e;
endpackage

// File: rtl/reg_dump_ctrl_if.sv
// reg_dump_ctrl_if: valid/ready stream of register values tagged with their index
interface reg_dump_ctrl_if;
   import reg_dump_ctrl_pkg::*;
   logic              dump_valid;
   logic              dump_ready;
   logic [DATA_W-1:0] dump_data;
   logic [ADDR_W-1:0] dump_idx;
   modport master (output dump_valid, dump_data, dump_idx, input dump_ready);
   modport slave  (input dump_valid, dump_data, dump_idx, output dump_ready);
endinterface

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: sweeps the register file two registers per fetch and streams each value out,
// holding off CPU writes for the whole dump so the snapshot is coherent
module reg_dump_ctrl
   import reg_dump_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              hold_cpu,
   output logic              done,
   output logic [ADDR_W-1:0] reg_src1,
   output logic [ADDR_W-1:0] reg_src2,
   input  logic [DATA_W-1:0] read_data1,
   input  logic [DATA_W-1:0] read_data2,
   reg_dump_ctrl_if.master   dump
);
   dump_state_e       state_q, state_d;
   logic [PAIR_W-1:0] pair_q, pair_d;
   logic [DATA_W-1:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d;
   logic              valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DUMP_IDLE;
         pair_q  <= '0;
         buf_a_q <= '0;
         buf_b_q <= '0;
      end else begin
         state_q <= state_d;
         pair_q  <= pair_d;
         buf_a_q <= buf_a_d;
         buf_b_q <= buf_b_d;
      end
   end

   // buffers load only in FETCH, so a stalled beat never re-reads the register file
   always_comb begin
      state_d = state_q;
      pair_d  = pair_q;
      buf_a_d = buf_a_q;
      buf_b_d = buf_b_q;
      case (state_q)
         DUMP_IDLE: if (start) begin
            state_d = DUMP_FETCH;
            pair_d  = '0;
         end
         DUMP_FETCH: begin
            buf_a_d = read_data1;
            buf_b_d = read_data2;
            state_d = DUMP_SEND_A;
         end
         DUMP_SEND_A: if (dump.dump_ready) state_d = DUMP_SEND_B;
         DUMP_SEND_B: if (dump.dump_ready) begin
            state_d = pair_q == LAST_PAIR ? DUMP_DONE : DUMP_FETCH;
            pair_d  = pair_q == LAST_PAIR ? pair_q : pair_q + 1'b1;
         end
         default: state_d = DUMP_IDLE;
      endcase
   end

   assign valid           = state_q == DUMP_SEND_A || state_q == DUMP_SEND_B;
   assign busy            = state_q != DUMP_IDLE;
   assign hold_cpu        = busy;
   assign done            = state_q == DUMP_DONE;
   assign reg_src1        = busy ? {pair_q, 1'b0} : '0;
   assign reg_src2        = busy ? {pair_q, 1'b1} : '0;
   assign dump.dump_valid = valid;
   assign dump.dump_data  = state_q == DUMP_SEND_A ? buf_a_q : state_q == DUMP_SEND_B ? buf_b_q : '0;
   assign dump.dump_idx   = valid ? {pair_q, state_q == DUMP_SEND_B} : '0;
endmodule
